// File: rtl/uart_baud_ctrl.sv
// uart_baud_ctrl: arbitrates, validates and applies baud changes with datapath drain and generator restart
module uart_baud_ctrl #(
  parameter int GEN_RST_CYC = 2,
  parameter int SETTLE_CYC = 16,
  parameter int DRAIN_TIMEOUT = 65535,
  parameter logic [16:0] RESET_BAUD = 17'd9600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [16:0] req_baud0,
  input  logic [16:0] req_baud1,
  output logic [1:0]  ack,
  output logic [1:0]  status,
  input  logic        tx_busy,
  input  logic        rx_busy,
  output logic        link_en,
  output logic [16:0] baud,
  output logic        gen_rst,
  output logic        ctrl_busy
);
  localparam int MX = DRAIN_TIMEOUT > GEN_RST_CYC ? (DRAIN_TIMEOUT > SETTLE_CYC ? DRAIN_TIMEOUT : SETTLE_CYC)
                                                  : (GEN_RST_CYC > SETTLE_CYC ? GEN_RST_CYC : SETTLE_CYC);
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [2:0] {IDLE, CHECK, DRAIN, APPLY, SETTLE, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [16:0] pend_baud, pend_n;
  logic grant, grant_n, last_grant, last_n, supported;
  logic [1:0] st_n;
  assign supported = pend_baud inside {17'd4800, 17'd9600, 17'd14400, 17'd19200,
                                       17'd38400, 17'd57600, 17'd115200, 17'd128000};
  // next state, grant selection and completion status
  always_comb begin
    nxt = state;
    pend_n = pend_baud;
    grant_n = grant;
    last_n = last_grant;
    st_n = 2'b00;
    case (state)
      IDLE: if (|req) begin
        grant_n = &req ? ~last_grant : req[1];
        last_n = grant_n;
        pend_n = grant_n ? req_baud1 : req_baud0;
        nxt = CHECK;
      end
      CHECK: begin
        nxt = !supported ? DONE : pend_baud == baud ? DONE : DRAIN;
        st_n = supported ? 2'b00 : 2'b01;
      end
      DRAIN: if (!tx_busy && !rx_busy) nxt = APPLY;
             else if (cnt == CW'(DRAIN_TIMEOUT - 1)) begin
               nxt = DONE;
               st_n = 2'b10;
             end
      APPLY: nxt = cnt == CW'(GEN_RST_CYC - 1) ? SETTLE : APPLY;
      SETTLE: nxt = cnt == CW'(SETTLE_CYC - 1) ? DONE : SETTLE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // state, counters and registered outputs derived from the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      pend_baud <= RESET_BAUD;
      grant <= 1'b0;
      last_grant <= 1'b1;
      baud <= RESET_BAUD;
      link_en <= 1'b1;
      ack <= 2'b00;
      status <= 2'b00;
      gen_rst <= 1'b0;
      ctrl_busy <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (nxt != state || state == IDLE) ? '0 : cnt + 1'b1;
      pend_baud <= pend_n;
      grant <= grant_n;
      last_grant <= last_n;
      baud <= (nxt == APPLY && state != APPLY) ? pend_baud : baud;
      link_en <= !(nxt inside {DRAIN, APPLY, SETTLE});
      ack <= nxt == DONE ? (grant ? 2'b10 : 2'b01) : 2'b00;
      status <= nxt == DONE ? st_n : 2'b00;
      gen_rst <= nxt == APPLY;
      ctrl_busy <= nxt != IDLE;
    end
  end
endmodule

// File: tb/tb_uart_baud_ctrl.sv
// tb_uart_baud_ctrl: randomized transactions checked cycle by cycle against a latency/arbitration model
module tb_uart_baud_ctrl;
  localparam int G = 2, S = 16, T = 20;
  logic clk = 0, rst = 1, tx_busy = 0, rx_busy = 0;
  logic [1:0] req = 0;
  logic [16:0] req_baud0 = 0, req_baud1 = 0;
  logic [1:0] ack, status;
  logic link_en, gen_rst, ctrl_busy;
  logic [16:0] baud;
  uart_baud_ctrl #(.GEN_RST_CYC(G), .SETTLE_CYC(S), .DRAIN_TIMEOUT(T), .RESET_BAUD(17'd9600)) dut (
    .clk(clk), .rst(rst), .req(req), .req_baud0(req_baud0), .req_baud1(req_baud1),
    .ack(ack), .status(status), .tx_busy(tx_busy), .rx_busy(rx_busy),
    .link_en(link_en), .baud(baud), .gen_rst(gen_rst), .ctrl_busy(ctrl_busy));
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;
  logic pend [2];
  logic [16:0] rate [2];
  logic [16:0] cur_baud = 17'd9600;
  logic last = 1'b1;
  logic [16:0] rates [8] = '{17'd4800, 17'd9600, 17'd14400, 17'd19200, 17'd38400, 17'd57600, 17'd115200, 17'd128000};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  function automatic logic supported(input logic [16:0] v);
    for (int i = 0; i < 8; i++) if (rates[i] == v) return 1'b1;
    return 1'b0;
  endfunction
  function automatic logic [16:0] pick();
    case ($urandom_range(0, 2))
      0: return rates[$urandom_range(0, 7)];
      1: return cur_baud;
      default: return 17'($urandom);
    endcase
  endfunction
  task automatic drive_req();
    req = {pend[1], pend[0]};
    req_baud0 = rate[0];
    req_baud1 = rate[1];
  endtask
  task automatic set_busy(input int k, input int b);
    logic bz;
    if (k >= 2 && k < 2 + b) bz = 1'b1;
    else if (k == 2 + b) bz = 1'b0;
    else bz = 1'($urandom_range(0, 1));
    {tx_busy, rx_busy} = bz ? 2'($urandom_range(1, 3)) : 2'b00;
  endtask
  task automatic run_txn(input int b);
    logic g;
    logic [16:0] pb, old;
    int kind, d, a;
    @(negedge clk);
    drive_req();
    check("idle_busy", ctrl_busy, 0);
    check("idle_ack", ack, 0);
    check("idle_link", link_en, 1);
    check("idle_baud", baud, cur_baud);
    g = (pend[0] && pend[1]) ? !last : pend[1];
    last = g;
    pb = rate[g];
    old = cur_baud;
    kind = !supported(pb) ? 0 : pb == old ? 1 : b >= T ? 3 : 2;
    d = kind < 2 ? 2 : kind == 3 ? 2 + T : 3 + b + G + S;
    a = 3 + b;
    set_busy(0, b);
    for (int k = 1; k <= d; k++) begin
      @(negedge clk);
      check("ack", ack, k == d ? (g ? 2 : 1) : 0);
      if (k == d) check("status", status, kind == 0 ? 1 : kind == 3 ? 2 : 0);
      check("link_en", link_en, !(kind >= 2 && k >= 2 && k < d));
      check("gen_rst", gen_rst, kind == 2 && k >= a && k < a + G);
      check("baud", baud, (kind == 2 && k >= a) ? pb : old);
      check("ctrl_busy", ctrl_busy, 1);
      set_busy(k, b);
    end
    pend[g] = 1'b0;
    drive_req();
    if (kind == 2) cur_baud = pb;
  endtask
  task automatic reset_mid();
    @(negedge clk);
    pend[0] = 1'b1;
    pend[1] = 1'b0;
    rate[0] = cur_baud == 17'd38400 ? 17'd14400 : 17'd38400;
    drive_req();
    {tx_busy, rx_busy} = 2'b00;
    repeat (3 + G + 5) @(negedge clk);
    check("settle_baud", baud, rate[0]);
    check("settle_link", link_en, 0);
    rst = 1;
    pend[0] = 1'b0;
    drive_req();
    @(negedge clk);
    check("rst_baud", baud, 9600);
    check("rst_link", link_en, 1);
    check("rst_gen", gen_rst, 0);
    check("rst_busy", ctrl_busy, 0);
    check("rst_ack", ack, 0);
    rst = 0;
    cur_baud = 17'd9600;
    last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_ack", ack, 0);
      check("post_rst_busy", ctrl_busy, 0);
    end
  endtask
  initial begin
    pend[0] = 0; pend[1] = 0; rate[0] = 0; rate[1] = 0;
    repeat (3) @(negedge clk);
    check("reset_baud", baud, 9600);
    check("reset_link", link_en, 1);
    check("reset_ack", ack, 0);
    check("reset_status", status, 0);
    check("reset_gen", gen_rst, 0);
    check("reset_busy", ctrl_busy, 0);
    rst = 0;
    pend[0] = 1; pend[1] = 1; rate[0] = 17'd4800; rate[1] = 17'd57600;
    run_txn(0);
    run_txn(0);
    pend[0] = 1; pend[1] = 1; rate[0] = 17'd115200; rate[1] = 17'd19200;
    run_txn(0);
    run_txn(0);
    pend[0] = 1; rate[0] = 17'd12345;
    run_txn(0);
    pend[1] = 1; rate[1] = cur_baud;
    run_txn(0);
    pend[0] = 1; rate[0] = cur_baud == 17'd115200 ? 17'd128000 : 17'd115200;
    run_txn(10);
    pend[1] = 1; rate[1] = cur_baud == 17'd4800 ? 17'd9600 : 17'd4800;
    run_txn(T + 5);
    reset_mid();
    pend[0] = 1; rate[0] = 17'd115200;
    run_txn(0);
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          rate[i] = pick();
        end
      if (!pend[0] && !pend[1]) begin
        pend[n % 2] = 1'b1;
        rate[n % 2] = pick();
      end
      run_txn($urandom_range(0, 3) == 0 ? $urandom_range(T, T + 3) : $urandom_range(0, 12));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
